keycode_dir_queue: RTL

Decodes the level-style USB keyboard keycode written by the SoC PIO into discrete snake-direction events.
- Filters out duplicate and 180° reversal turns.
- Buffers accepted turns in a small FIFO so that fast key sequences are not lost between frames.
- Sits between the SoC keycode export and the snake motion logic; the snake pops at most one turn per frame through a valid/ready handshake.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 40 ++++
 rtl/keycode_dir_queue.sv | 59 +++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction encoding, HID keycodes and keycode/direction helpers
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam logic [7:0] KC_W = 8'h1A;
  localparam logic [7:0] KC_A = 8'h04;
  localparam logic [7:0] KC_S = 8'h16;
  localparam logic [7:0] KC_D = 8'h07;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } key_hit_t;

  function automatic key_hit_t key_to_dir(input logic [7:0] kc);
    key_hit_t r;
    r.hit = kc == KC_W || kc == KC_A || kc == KC_S || kc == KC_D;
    r.dir = kc == KC_W ? UP : kc == KC_A ? LEFT : kc == KC_S ? DOWN : RIGHT;
    return r;
  endfunction

  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: wrap-bit pointer FIFO; a push into a full FIFO lands only when a pop frees a slot
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty   = wp == rp;
  assign full    = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign count   = wp - rp;
  assign dout    = mem[rp[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // pointer advance; no bypass, so a pop on empty is simply ignored
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  // storage write; contents are don't-care until a pointer covers them
  always_ff @(posedge Clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/keycode_dir_queue.sv
// keycode_dir_queue: turns held HID keycodes into filtered, queued snake turn events
module keycode_dir_queue
  import snake_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [7:0]             keycode,
  input  logic                   dir_ready,
  output logic                   dir_valid,
  output logic [1:0]             dir_out,
  output logic [1:0]             cur_dir,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);
  logic [7:0] kc_q, kc_prev;
  dir_t last_acc;
  key_hit_t ev;
  logic press, accept, full, empty, drop;
  assign ev        = key_to_dir(kc_q);
  assign press     = kc_q != kc_prev && ev.hit;
  assign accept    = press && ev.dir != last_acc && ev.dir != dir_reverse(last_acc);
  assign drop      = accept && full && !dir_ready;
  assign dir_valid = !empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(2)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (accept),
    .pop   (dir_ready),
    .din   (ev.dir),
    .dout  (dir_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // keycode pipeline, turn filter state, applied heading and drop accounting
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q       <= '0;
      kc_prev    <= '0;
      last_acc   <= RIGHT;
      cur_dir    <= RIGHT;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      kc_q     <= keycode;
      kc_prev  <= kc_q;
      overflow <= drop;
      if (accept && !drop) last_acc <= ev.dir;
      if (drop && !(&drop_count)) drop_count <= drop_count + 1'b1;
      if (dir_valid && dir_ready) cur_dir <= dir_out;
    end
  end
endmodule
